// File: rtl/hazard_pkg.sv
// Shared pipeline timing encodings and default latencies for the hazard scoreboard.
package hazard_pkg;

    localparam int DEF_NREG    = 32;
    localparam int DEF_TW      = 4;
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    // Tuse: cycles from D until the operand is consumed.
    // Tnew: cycles from D until the result can be forwarded.
    localparam int TUSE_RS_E = 0;
    localparam int TUSE_LOAD = 2;
    localparam int TNEW_ALU  = 2;
    localparam int TNEW_LOAD = 3;
    localparam int TNEW_MF   = 2;

    typedef enum logic [1:0] {
        MD_NONE,
        MD_MUL,
        MD_DIV
    } md_op_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int md_cnt_width(input int mul_lat, input int div_lat);
        return $clog2(max_int(mul_lat, div_lat) + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request bundle toward the hazard scoreboard and its stall/status replies.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int TW   = DEF_TW
);
    localparam int AW = $clog2(NREG);

    logic            d_valid;
    logic [AW-1:0]   d_rs;
    logic [AW-1:0]   d_rt;
    logic [TW-1:0]   d_tuse_rs;
    logic [TW-1:0]   d_tuse_rt;
    logic [AW-1:0]   d_wr_addr;
    logic [TW-1:0]   d_tnew;
    logic            d_md_start;
    logic            d_md_div;
    logic            d_md_use;
    logic            stall;
    logic            md_busy;
    logic [NREG-1:0] pending;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_wr_addr, d_tnew, d_md_start, d_md_div, d_md_use,
        input  stall, md_busy, pending
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_wr_addr, d_tnew, d_md_start, d_md_div, d_md_use,
        output stall, md_busy, pending
    );

endinterface

// File: rtl/sb_counter.sv
// Per-register "cycles until forwardable" countdown; a fresh load always beats the decrement.
module sb_counter
    import hazard_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] cnt,
    output logic          nonzero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign nonzero = |cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks in-flight GPR writers and the multiply/divide unit,
// and raises a combinational D-stage stall when an operand would be needed too early.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = DEF_NREG,
    parameter int TW      = DEF_TW,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    hazard_scoreboard_if.slave  sb
);

    localparam int AW  = $clog2(NREG);
    localparam int MDW = md_cnt_width(MUL_LAT, DIV_LAT);

    logic            issue;
    logic [TW-1:0]   load_val;
    logic [TW-1:0]   cnt [NREG];
    logic [NREG-1:0] pend;
    logic            stall_rs;
    logic            stall_rt;
    logic            stall_md;
    logic [MDW-1:0]  md_cnt;
    md_op_e          md_op;

    // The counter is loaded one stage after D, so one cycle of Tnew has already elapsed.
    assign load_val = (sb.d_tnew == '0) ? '0 : sb.d_tnew - 1'b1;

    assign cnt[0]  = '0;
    assign pend[0] = 1'b0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_reg
            sb_counter #(
                .TW       (TW)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .clear    (flush),
                .load     (issue && (sb.d_wr_addr == AW'(r))),
                .load_val (load_val),
                .cnt      (cnt[r]),
                .nonzero  (pend[r])
            );
        end
    endgenerate

    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        stall_md = 1'b0;
        if (sb.d_rs != '0) begin
            stall_rs = cnt[sb.d_rs] > sb.d_tuse_rs;
        end
        if (sb.d_rt != '0) begin
            stall_rt = cnt[sb.d_rt] > sb.d_tuse_rt;
        end
        stall_md = sb.d_md_use && (md_cnt != '0);
    end

    assign sb.stall = sb.d_valid & (stall_rs | stall_rt | stall_md);
    assign issue    = sb.d_valid & ~sb.stall & ~flush;

    always_comb begin
        md_op = MD_NONE;
        if (issue && sb.d_md_start) begin
            md_op = sb.d_md_div ? MD_DIV : MD_MUL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (flush) begin
            md_cnt <= '0;
        end else begin
            case (md_op)
                MD_DIV:  md_cnt <= MDW'(DIV_LAT);
                MD_MUL:  md_cnt <= MDW'(MUL_LAT);
                default: if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
            endcase
        end
    end

    assign sb.md_busy = |md_cnt;
    assign sb.pending = pend;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations are queued per step and popped at the sample point.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREG    = 32;
    localparam int TW      = 4;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    localparam int AW      = $clog2(NREG);

    typedef struct {
        string           tag;
        logic            stall;
        logic            md_busy;
        logic [NREG-1:0] pending;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;
    exp_t sb_q[$];
    int   total;
    int   bad;

    hazard_scoreboard_if #(.NREG(NREG), .TW(TW)) bus ();

    hazard_scoreboard #(
        .NREG    (NREG),
        .TW      (TW),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .sb      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NREG-1:0] bit_of(input int n);
        logic [NREG-1:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic apply_stimulus(input logic v, input int rs, input int rt, input int trs,
                                  input int trt, input int wr, input int tnew,
                                  input logic ms, input logic md, input logic mu);
        bus.d_valid    = v;
        bus.d_rs       = AW'(rs);
        bus.d_rt       = AW'(rt);
        bus.d_tuse_rs  = TW'(trs);
        bus.d_tuse_rt  = TW'(trt);
        bus.d_wr_addr  = AW'(wr);
        bus.d_tnew     = TW'(tnew);
        bus.d_md_start = ms;
        bus.d_md_div   = md;
        bus.d_md_use   = mu;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic e_stall, input logic e_busy,
                              input logic [NREG-1:0] e_pend);
        exp_t e;
        e.tag     = tag;
        e.stall   = e_stall;
        e.md_busy = e_busy;
        e.pending = e_pend;
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            assert (bus.stall === e.stall) else begin
                bad++;
                $error("[TB] FAIL %s.stall observed=%b expected=%b", e.tag, bus.stall, e.stall);
            end
            total++;
            assert (bus.md_busy === e.md_busy) else begin
                bad++;
                $error("[TB] FAIL %s.md_busy observed=%b expected=%b", e.tag, bus.md_busy, e.md_busy);
            end
            total++;
            assert (bus.pending === e.pending) else begin
                bad++;
                $error("[TB] FAIL %s.pending observed=%h expected=%h", e.tag, bus.pending, e.pending);
            end
        end
    endtask

    // One D-stage cycle: inputs are already driven at posedge+1, sample at posedge+3.
    task automatic cycle(input string tag, input logic e_stall, input logic e_busy,
                         input logic [NREG-1:0] e_pend);
        expect_out(tag, e_stall, e_busy, e_pend);
        #2;
        check_output();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        flush = 1'b0;
        apply_stimulus(1'b1, 2, 3, 0, 0, 4, TNEW_LOAD, 1'b1, 1'b1, 1'b1);
        #12;
        expect_out("reset_state", 1'b0, 1'b0, '0);
        check_output();
        #6;
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] load-use: lw $2 then add $3,$2,$1");
        apply_stimulus(1'b1, 29, 0, 1, 0, 2, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("lw2", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 2, 1, 1, 1, 3, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("add_stall", 1'b1, 1'b0, bit_of(2));
        cycle("add_go", 1'b0, 1'b0, bit_of(2));
        idle();
        cycle("p2_clear", 1'b0, 1'b0, bit_of(3));
        cycle("p3_clear", 1'b0, 1'b0, '0);

        $display("[TB] ALU result into branch and store");
        apply_stimulus(1'b1, 0, 0, 1, 0, 2, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("ori2", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 2, 0, TUSE_RS_E, TUSE_RS_E, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle("beq_stall", 1'b1, 1'b0, bit_of(2));
        cycle("beq_go", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 1, 0, 2, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("ori2b", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 29, 2, 1, TUSE_LOAD, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle("sw_nostall", 1'b0, 1'b0, bit_of(2));
        idle();
        cycle("sw_after", 1'b0, 1'b0, '0);

        $display("[TB] immediate-forward producer and writes to $0");
        apply_stimulus(1'b1, 0, 0, 0, 0, 6, 0, 1'b0, 1'b0, 1'b0);
        cycle("tnew0", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 6, 6, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle("tnew0_use", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 0, 0, 0, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("wr0", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle("wr0_after", 1'b0, 1'b0, '0);

        $display("[TB] divide then mflo");
        apply_stimulus(1'b1, 8, 9, 1, 1, 0, 0, 1'b1, 1'b1, 1'b1);
        cycle("div", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 0, 0, 8, TNEW_MF, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= DIV_LAT; k++) begin
            cycle($sformatf("mflo_wait%0d", k), 1'b1, 1'b1, '0);
        end
        cycle("mflo_go", 1'b0, 1'b0, '0);
        idle();
        cycle("mflo_after", 1'b0, 1'b0, bit_of(8));

        $display("[TB] multiply, unrelated ALU op, then mfhi");
        apply_stimulus(1'b1, 0, 0, 1, 1, 0, 0, 1'b1, 1'b0, 1'b1);
        cycle("mult", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 1, 1, 3, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("add_md_free", 1'b0, 1'b1, '0);
        apply_stimulus(1'b1, 0, 0, 0, 0, 9, TNEW_MF, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= MUL_LAT - 1; k++) begin
            cycle($sformatf("mfhi_wait%0d", k), 1'b1, 1'b1, (k == 1) ? bit_of(3) : '0);
        end
        cycle("mfhi_go", 1'b0, 1'b0, '0);
        idle();
        cycle("mfhi_after", 1'b0, 1'b0, bit_of(9));

        $display("[TB] back-to-back writers of one register");
        apply_stimulus(1'b1, 29, 0, 1, 0, 4, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("lw4", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 1, 0, 4, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("ori4", 1'b0, 1'b0, bit_of(4));
        apply_stimulus(1'b1, 4, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle("beq4_stall", 1'b1, 1'b0, bit_of(4));
        cycle("beq4_go", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 29, 0, 1, 0, 4, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("lw4b", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 0, 0, 4, 0, 1'b0, 1'b0, 1'b0);
        cycle("imm4", 1'b0, 1'b0, bit_of(4));
        apply_stimulus(1'b1, 4, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle("beq4_free", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 0, 0, 1, 0, 7, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("ori7", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 29, 0, 1, 0, 7, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("lw7", 1'b0, 1'b0, bit_of(7));
        apply_stimulus(1'b1, 7, 0, 1, 1, 3, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("add7_stall", 1'b1, 1'b0, bit_of(7));
        cycle("add7_go", 1'b0, 1'b0, bit_of(7));
        idle();
        cycle("add7_after", 1'b0, 1'b0, bit_of(3));

        $display("[TB] flush with live register and MDU countdowns");
        apply_stimulus(1'b1, 0, 0, 1, 1, 0, 0, 1'b1, 1'b1, 1'b1);
        cycle("div_f", 1'b0, 1'b0, '0);
        idle();
        cycle("f_idle1", 1'b0, 1'b1, '0);
        cycle("f_idle2", 1'b0, 1'b1, '0);
        apply_stimulus(1'b1, 0, 0, 1, 0, 5, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("lw5", 1'b0, 1'b1, '0);
        flush = 1'b1;
        apply_stimulus(1'b1, 0, 0, 1, 1, 9, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("flush_cyc", 1'b0, 1'b1, bit_of(5));
        flush = 1'b0;
        apply_stimulus(1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle("post_flush", 1'b0, 1'b0, '0);

        $display("[TB] asynchronous reset mid-countdown");
        apply_stimulus(1'b1, 0, 0, 1, 1, 0, 0, 1'b1, 1'b1, 1'b1);
        cycle("div_r", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 29, 0, 1, 0, 10, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("lw10", 1'b0, 1'b1, '0);
        apply_stimulus(1'b1, 10, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        expect_out("pre_reset", 1'b1, 1'b1, bit_of(10));
        #2;
        check_output();
        #1;
        reset = 1'b0;
        #1;
        expect_out("rst_async", 1'b0, 1'b0, '0);
        check_output();
        @(posedge clk);
        #1;
        expect_out("rst_hold", 1'b0, 1'b0, '0);
        #2;
        check_output();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle("resume_idle", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 29, 0, 1, 0, 11, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        cycle("lw11", 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 11, 0, 1, 1, 3, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        cycle("add11_stall", 1'b1, 1'b0, bit_of(11));
        cycle("add11_go", 1'b0, 1'b0, bit_of(11));
        idle();
        cycle("add11_after", 1'b0, 1'b0, bit_of(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural GPRs; register 0 is hard-wired zero.
REQ-002 SHALL have parameter TW, default 4, width of Tuse/Tnew fields.
REQ-003 SHALL have parameter MUL_LAT, default 5, cycles MDU stays busy after a mult/multu issue.
REQ-004 SHALL have parameter DIV_LAT, default 10, cycles MDU stays busy after a div/divu issue.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous clear of all pending state.
REQ-008 SHALL have port d_valid  input  1  D-stage holds a real instruction.
REQ-009 SHALL have port d_rs, d_rt  input  $clog2(NREG) each  D-stage source registers.
REQ-010 SHALL have port d_tuse_rs, d_tuse_rt  input  TW each  cycles until each source is needed.
REQ-011 SHALL have port d_wr_addr  input  $clog2(NREG)  destination register; 0 means no write.
REQ-012 SHALL have port d_tnew  input  TW  D-relative cycles until the result is forwardable.
REQ-013 SHALL have port d_md_start, d_md_div  input  1 each  instruction starts MDU op; op is divide.
REQ-014 SHALL have port d_md_use  input  1  instruction is any mult/div/mt/mf.
REQ-015 SHALL have port stall  output  1  freeze F/D, inject bubble into E.
REQ-016 SHALL have port md_busy  output  1  MDU countdown nonzero.
REQ-017 SHALL have port pending  output  NREG  bit r set when cnt[r] nonzero; bit 0 always 0.

Function
REQ-018 SHALL keep per-register counter cnt[r] of TW bits for r=1..NREG-1.
REQ-019 SHALL define issue = d_valid & ~stall & ~flush.
REQ-020 SHALL, on issue with d_wr_addr!=0, load cnt[d_wr_addr] with max(d_tnew-1, 0).
REQ-021 SHALL, every other edge, decrement each nonzero cnt[r] by 1, saturating at 0.
REQ-022 SHALL, when issue load and decrement target the same register in one edge, apply the load (newest writer wins).
REQ-023 SHALL assert stall_rs when d_rs!=0 and cnt[d_rs] > d_tuse_rs; stall_rt likewise for d_rt.
REQ-024 SHALL hold md_cnt, width $clog2(max(MUL_LAT,DIV_LAT)+1); on issue with d_md_start, load DIV_LAT if d_md_div else MUL_LAT.
REQ-025 SHALL, when not loaded, decrement md_cnt saturating at 0; md_busy = (md_cnt!=0).
REQ-026 SHALL assert stall_md when d_md_use and md_busy.
REQ-027 SHALL drive stall = d_valid & (stall_rs | stall_rt | stall_md), combinationally, zero cycle latency.
REQ-028 SHALL, on flush, clear all cnt and md_cnt at the next edge; flush dominates issue.
REQ-029 SHALL treat d_tnew=0 as an immediate-forward producer: no stall against it.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear all cnt, md_cnt; stall, md_busy, pending read 0.
REQ-031 SHALL resume counting on the first rising edge after reset deasserts; reset mid-countdown discards all pending state.

Structure
REQ-032 SHALL place Tuse/Tnew encodings (TUSE_RS_E=0, TUSE_LOAD=2, TNEW_ALU=2, TNEW_LOAD=3, TNEW_MF=2) and default latencies in shared package hazard_pkg.
REQ-033 SHALL instantiate sub-module sb_counter (load/decrement saturating counter, TW bits) once per register r=1..NREG-1 via generate.

Verification
REQ-034 SHALL cover lw $2 (tnew=3) then add $3,$2,$1 (tuse_rs=1): stall high 1 cycle, then low; pending[2] clears 2 edges after issue.
REQ-035 SHALL cover ori $2 (tnew=2) then beq $2 (tuse=0): stall 1 cycle; sw $2 (tuse_rt=2) after ori: no stall.
REQ-036 SHALL cover div issue then mflo: stall for exactly DIV_LAT=10 cycles, md_busy falls on cycle 10.
REQ-037 SHALL cover lw $4 followed by ori $4 writes: second load of cnt[4] overrides; consumer stall based on ori only.
REQ-038 SHALL cover flush asserted while cnt[5]=2 and md_cnt=7: next cycle pending=0, md_busy=0, stall=0.
REQ-039 SHALL cover reset=0 asserted mid-countdown between edges: outputs 0 immediately, no edge required.
